// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register-file read, writeback bypass, scoreboard
// hazard stall and a registered valid/ready slot toward execute.
module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREG   = 16,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wb,
    output logic [ADDR_W-1:0] rf_a1,
    output logic [ADDR_W-1:0] rf_a2,
    input  logic [DATA_W-1:0] rf_d1,
    input  logic [DATA_W-1:0] rf_d2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wb,
    output logic [DATA_W-1:0] out_opa,
    output logic [DATA_W-1:0] out_opb
);

    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   out_op_q, out_op_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;
    logic              out_wb_q, out_wb_d;
    logic [DATA_W-1:0] out_opa_q, out_opa_d;
    logic [DATA_W-1:0] out_opb_q, out_opb_d;
    logic [NREG-1:0]   pend_q, pend_d;

    logic              byp1, byp2, bypd;
    logic              haz1, haz2, hazw;
    logic              hazard, slot_free, fire;
    logic [DATA_W-1:0] opa, opb;

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

    // The register file commits wb_data only at the edge, so bypass it here.
    always_comb begin
        byp1      = wb_valid && (wb_addr == in_rs1);
        byp2      = wb_valid && (wb_addr == in_rs2);
        bypd      = wb_valid && (wb_addr == in_rd);
        opa       = byp1 ? wb_data : rf_d1;
        opb       = byp2 ? wb_data : rf_d2;
        haz1      = pend_q[in_rs1] && !byp1;
        haz2      = pend_q[in_rs2] && !byp2;
        hazw      = in_wb && pend_q[in_rd] && !bypd;
        hazard    = haz1 || haz2 || hazw;
        slot_free = !out_valid_q || out_ready;
        in_ready  = slot_free && !hazard && !flush;
        fire      = in_valid && in_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_rd_d    = out_rd_q;
        out_wb_d    = out_wb_q;
        out_opa_d   = out_opa_q;
        out_opb_d   = out_opb_q;
        pend_d      = pend_q;
        if (flush) begin
            out_valid_d = 1'b0;
            pend_d      = '0;
        end else begin
            if (fire) begin
                out_valid_d = 1'b1;
                out_op_d    = in_op;
                out_rd_d    = in_rd;
                out_wb_d    = in_wb;
                out_opa_d   = opa;
                out_opb_d   = opb;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            // Set after clear so an issue to the retiring register stays pending.
            if (wb_valid) begin
                pend_d[wb_addr] = 1'b0;
            end
            if (fire && in_wb) begin
                pend_d[in_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_rd_q    <= '0;
            out_wb_q    <= 1'b0;
            out_opa_q   <= '0;
            out_opb_q   <= '0;
            pend_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_rd_q    <= out_rd_d;
            out_wb_q    <= out_wb_d;
            out_opa_q   <= out_opa_d;
            out_opb_q   <= out_opb_d;
            pend_q      <= pend_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_rd    = out_rd_q;
    assign out_wb    = out_wb_q;
    assign out_opa   = out_opa_q;
    assign out_opb   = out_opb_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus a randomized run
// against a register-file / scoreboard reference model.
module tb_operand_fetch_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [3:0]  in_rs1, in_rs2, in_rd;
    logic        in_wb;
    logic [3:0]  rf_a1, rf_a2;
    logic [31:0] rf_d1, rf_d2;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_op;
    logic [3:0]  out_rd;
    logic        out_wb;
    logic [31:0] out_opa, out_opb;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf_mem [16];
    logic [15:0] m_pend;
    logic        m_valid;
    logic [7:0]  m_op;
    logic [3:0]  m_rd;
    logic        m_wb;
    logic [31:0] m_opa, m_opb;

    assign rf_d1 = rf_mem[rf_a1];
    assign rf_d2 = rf_mem[rf_a2];

    operand_fetch_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wb(in_wb),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_d1(rf_d1), .rf_d2(rf_d2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rd(out_rd), .out_wb(out_wb), .out_opa(out_opa), .out_opb(out_opb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A register is busy if it is in flight and not retiring this very cycle.
    function automatic logic busy(input logic [3:0] r);
        return m_pend[r] && !(wb_valid && wb_addr == r);
    endfunction

    function automatic logic model_ready();
        logic room;
        room = !m_valid || out_ready;
        return room && !flush && !busy(in_rs1) && !busy(in_rs2)
               && !(in_wb && busy(in_rd));
    endfunction

    function automatic logic [31:0] reg_now(input logic [3:0] r);
        return (wb_valid && wb_addr == r) ? wb_data : rf_mem[r];
    endfunction

    task automatic model_clear();
        m_pend  = '0;
        m_valid = 1'b0;
        m_op    = '0;
        m_rd    = '0;
        m_wb    = 1'b0;
        m_opa   = '0;
        m_opb   = '0;
    endtask

    // Advance one clock: environment register file and reference model.
    task automatic cycle();
        logic        take;
        logic [31:0] a, b;
        logic [7:0]  op;
        logic [3:0]  rd, wa;
        logic        wbf, wv, fl, rs, ordy;
        logic [31:0] wd;
        take = in_valid && model_ready();
        a    = reg_now(in_rs1);
        b    = reg_now(in_rs2);
        op   = in_op;
        rd   = in_rd;
        wbf  = in_wb;
        wv   = wb_valid;
        wa   = wb_addr;
        wd   = wb_data;
        fl   = flush;
        rs   = reset;
        ordy = out_ready;
        @(posedge clk);
        #1;
        if (wv) rf_mem[wa] = wd;
        if (!rs) begin
            model_clear();
        end else if (fl) begin
            m_valid = 1'b0;
            m_pend  = '0;
        end else begin
            if (take) begin
                m_valid = 1'b1;
                m_op    = op;
                m_rd    = rd;
                m_wb    = wbf;
                m_opa   = a;
                m_opb   = b;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (wv) m_pend[wa] = 1'b0;
            if (take && wbf) m_pend[rd] = 1'b1;
        end
    endtask

    task automatic set_instr(input logic v, input logic [3:0] r1,
                             input logic [3:0] r2, input logic [3:0] rd,
                             input logic wbf, input logic [7:0] op);
        in_valid = v;
        in_rs1   = r1;
        in_rs2   = r2;
        in_rd    = rd;
        in_wb    = wbf;
        in_op    = op;
    endtask

    task automatic set_wb(input logic v, input logic [3:0] a,
                          input logic [31:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        set_wb(1'b0, 4'd0, 32'd0);
        set_instr(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 8'hA5);
        for (int i = 0; i < 16; i++) rf_mem[i] = 32'h100 + i;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready: got %0b want 1", in_ready);
            end
            checks++;
            if ({out_valid, out_op, out_rd, out_wb, out_opa, out_opb} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: valid=%0b op=%h opa=%h want all 0",
                         out_valid, out_op, out_opa);
            end
            cycle();
        end
        reset = 1'b1;
        #1;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_opa !== 32'h101 || out_opb !== 32'h102
            || out_op !== 8'hA5) begin
            errors++;
            $display("FAIL reset_release: valid=%0b opa=%h opb=%h op=%h want 1 101 102 a5",
                     out_valid, out_opa, out_opb, out_op);
        end
    endtask

    task automatic test_plain_issue();
        set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 8'h00);
        out_ready = 1'b1;
        set_wb(1'b1, 4'd3, 32'd5);
        cycle();
        set_wb(1'b1, 4'd4, 32'd7);
        cycle();
        set_wb(1'b0, 4'd0, 32'd0);
        out_ready = 1'b0;
        set_instr(1'b1, 4'd3, 4'd4, 4'd5, 1'b1, 8'h11);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL plain_in_ready: got %0b want 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_opa !== 32'd5 || out_opb !== 32'd7
            || out_rd !== 4'd5 || out_wb !== 1'b1 || out_op !== 8'h11) begin
            errors++;
            $display("FAIL plain_issue: v=%0b opa=%0d opb=%0d rd=%0d wb=%0b op=%h want 1 5 7 5 1 11",
                     out_valid, out_opa, out_opb, out_rd, out_wb, out_op);
        end
    endtask

    task automatic test_raw_stall();
        out_ready = 1'b1;
        set_instr(1'b1, 4'd5, 4'd4, 4'd1, 1'b0, 8'h22);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL raw_stall[%0d]: in_ready got %0b want 0", i, in_ready);
            end
            cycle();
        end
        set_wb(1'b1, 4'd5, 32'h2A);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_release: in_ready got %0b want 1", in_ready);
        end
        cycle();
        set_wb(1'b0, 4'd0, 32'd0);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_opa !== 32'h2A || out_opb !== 32'd7) begin
            errors++;
            $display("FAIL raw_bypass: v=%0b opa=%h opb=%h want 1 2a 7",
                     out_valid, out_opa, out_opb);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_instr(1'b1, 4'd3, 4'd4, 4'd7, 1'b0, 8'h33);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready);
            end
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_op !== 8'h22 || out_opa !== 32'h2A) begin
                errors++;
                $display("FAIL bp_hold[%0d]: v=%0b op=%h opa=%h want 1 22 2a",
                         i, out_valid, out_op, out_opa);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready got %0b want 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_op !== 8'h33 || out_opa !== 32'd5
            || out_rd !== 4'd7) begin
            errors++;
            $display("FAIL bp_next_load: v=%0b op=%h opa=%0d rd=%0d want 1 33 5 7",
                     out_valid, out_op, out_opa, out_rd);
        end
    endtask

    task automatic test_same_reg();
        out_ready = 1'b1;
        set_instr(1'b1, 4'd3, 4'd4, 4'd6, 1'b1, 8'h44);
        set_wb(1'b1, 4'd6, 32'h99);
        cycle();
        set_wb(1'b0, 4'd0, 32'd0);
        set_instr(1'b1, 4'd0, 4'd0, 4'd6, 1'b1, 8'h45);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall: in_ready got %0b want 0", in_ready);
        end
        cycle();
        set_wb(1'b1, 4'd6, 32'h77);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_release: in_ready got %0b want 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        cycle();
        set_wb(1'b0, 4'd0, 32'd0);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_instr(1'b1, 4'd3, 4'd4, 4'd2, 1'b1, 8'h55);
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: out_valid got %0b want 1", out_valid);
        end
        flush = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks: in_ready got %0b want 0", in_ready);
        end
        cycle();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: out_valid got %0b want 0", out_valid);
        end
        set_instr(1'b1, 4'd2, 4'd2, 4'd9, 1'b0, 8'h56);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_pend_clear: in_ready got %0b want 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_op !== 8'h56) begin
            errors++;
            $display("FAIL flush_reissue: v=%0b op=%h want 1 56", out_valid, out_op);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        set_instr(1'b1, 4'd3, 4'd4, 4'd8, 1'b1, 8'h66);
        cycle();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        checks++;
        if (out_valid !== 1'b0 || out_opa !== 32'd0 || out_op !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async: v=%0b opa=%h op=%h want 0 0 0",
                     out_valid, out_opa, out_op);
        end
        cycle();
        reset = 1'b1;
        set_instr(1'b1, 4'd8, 4'd8, 4'd1, 1'b0, 8'h67);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pend: in_ready got %0b want 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_op !== 8'h67) begin
            errors++;
            $display("FAIL midreset_accept: v=%0b op=%h want 1 67", out_valid, out_op);
        end
    endtask

    task automatic test_random();
        logic [77:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            set_instr($urandom_range(0, 9) < 7, 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                      $urandom_range(0, 9) < 6, 8'($urandom));
            set_wb($urandom_range(0, 9) < 4, 4'($urandom_range(0, 7)), $urandom);
            out_ready = $urandom_range(0, 9) < 6;
            flush = $urandom_range(0, 99) < 4;
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("FAIL rand_in_ready[%0d]: got %0b want %0b",
                         n, in_ready, model_ready());
            end
            cycle();
            got = {out_valid, out_op, out_rd, out_wb, out_opa, out_opb};
            exp = {m_valid, m_op, m_rd, m_wb, m_opa, m_opb};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_out[%0d]: got %h want %h", n, got, exp);
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
        set_wb(1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_plain_issue();
        test_raw_stall();
        test_backpressure();
        test_same_reg();
        test_flush();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
